divider_sequencer: RTL and testbench
====================================

Name: divider_sequencer

Overview:
- Operand front-end for `divider`. Accepts (dividend, divisor) pairs on a valid/ready stream and presents them to `divider` as stable registered operands.
- Waits out the divider's fixed latency, then captures `quotient` and returns it on a valid/ready result stream.
- Intercepts divide-by-zero so `divider` never sees divisor 0. Keeps a saturating count of zero-divisor events.

Parameters:
- DIV_LATENCY, 1, clock cycles from operands stable at divider inputs to quotient valid at divider output; legal range ≥ 1.
- CNT_WIDTH, 16, width of the zero-divisor event counter.
- Data width is SIZE_DATA from package_settings; it is not a module parameter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- in_dividend  in  SIZE_DATA  unsigned dividend.
- in_divisor  in  SIZE_DATA  unsigned divisor.
- div_dividend  out  SIZE_DATA  drives `divider`.dividend.
- div_divisor  out  SIZE_DATA  drives `divider`.divisor.
- div_quotient  in  SIZE_DATA  from `divider`.quotient.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_quotient  out  SIZE_DATA  result quotient, raw bits.
- out_div_by_zero  out  1  result came from a zero divisor.
- zero_count  out  CNT_WIDTH  saturating count of zero-divisor transactions.

Behaviour:
- Clock, reset: one clock; reset is synchronous and active-high, named clk and reset.
- Reset values:
  - State IDLE.
  - out_valid=0, out_quotient=0, out_div_by_zero=0.
  - div_dividend=0, div_divisor=1 (keeps the divider free of X/div-by-0 in simulation).
  - zero_count=0, wait counter=0.
- Reset mid-operation abandons any in-flight transaction; no result is emitted for it.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This is combinational from out_ready.
- Accept: edge where in_valid & in_ready.
- FSM states:
  - IDLE: wait for accept.
  - WAIT: count the divider latency.
  - DONE: hold result until out_ready.
- Accept, divisor≠0:
  - Register div_dividend / div_divisor at the accept edge E0.
  - Go to WAIT with cnt=DIV_LATENCY.
- WAIT, at each edge:
  - If cnt==0: capture out_quotient<=div_quotient, out_div_by_zero<=0, out_valid<=1, go to DONE.
  - Otherwise cnt<=cnt-1.
  - Result: out_valid rises DIV_LATENCY+1 cycles after E0 (2 cycles at default).
- Accept, divisor==0:
  - div_dividend / div_divisor are NOT updated.
  - At E0: out_quotient<={SIZE_DATA{1'b1}}, out_div_by_zero<=1, out_valid<=1, go to DONE. out_valid is high 1 cycle after accept.
  - zero_count<=zero_count+1, saturating at all-ones.
- DONE:
  - out_valid, out_quotient and out_div_by_zero hold stable until out_valid & out_ready.
  - On that edge, out_valid<=0 and state goes to IDLE, unless a new accept occurs on the same edge. In that case the new transaction is processed exactly as from IDLE: for divisor≠0, out_valid drops and the state goes to WAIT; for divisor==0, out_valid stays 1 with the new result loaded.
- div_dividend / div_divisor remain stable throughout WAIT and DONE. Operand inputs are ignored whenever in_ready=0.
- Operands are unsigned. The quotient is passed through bit-exact with no sign interpretation.
- Only one transaction is ever in flight; there is no internal FIFO.
- zero_count is never cleared except by reset.

Test Plan:
1. Reset then 100/7 (SIZE_DATA=16, DIV_LATENCY=1), out_ready=1 → div_divisor=1 after reset; out_valid high exactly 2 cycles after accept, out_quotient=14, out_div_by_zero=0.
2. 0xFFFF/1 with out_ready=0 for 5 cycles → out_quotient=0xFFFF held stable; in_ready=0 throughout; result leaves on first out_ready cycle.
3. 50/0 → out_valid 1 cycle after accept, out_quotient=0xFFFF, out_div_by_zero=1, zero_count=1, div_divisor keeps previous value (7).
4. Back-to-back: in_valid held with 9/3 then 8/0 while out_ready=1 → 9/3 gives 3; the 8/0 accept on the DONE edge yields out_valid continuous, second result 0xFFFF with flag.
5. Reset asserted during WAIT of 200/10 → no out_valid afterward, all outputs at reset values next cycle; a subsequent 20/4 gives 5.
6. CNT_WIDTH=2, five zero-divisor transactions → zero_count reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/package_settings.sv
// Project-wide data-path settings shared by the divider and its front-end.
package package_settings;
    parameter int unsigned SIZE_DATA = 16;
endpackage

// File: rtl/divider_sequencer.sv
// Operand front-end for the fixed-latency divider: registers operands,
// waits out the divider latency, returns the quotient on a valid/ready
// stream, and diverts zero divisors so the divider never sees them.
module divider_sequencer
    import package_settings::*;
#(
    parameter int unsigned DIV_LATENCY = 1,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SIZE_DATA-1:0] in_dividend,
    input  logic [SIZE_DATA-1:0] in_divisor,
    output logic [SIZE_DATA-1:0] div_dividend,
    output logic [SIZE_DATA-1:0] div_divisor,
    input  logic [SIZE_DATA-1:0] div_quotient,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SIZE_DATA-1:0] out_quotient,
    output logic                 out_div_by_zero,
    output logic [CNT_WIDTH-1:0] zero_count
);

    localparam int unsigned WAIT_W = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic [SIZE_DATA-1:0] div_dividend_q, div_dividend_d;
    logic [SIZE_DATA-1:0] div_divisor_q, div_divisor_d;
    logic [SIZE_DATA-1:0] quotient_q, quotient_d;
    logic                 valid_q, valid_d;
    logic                 dbz_q, dbz_d;
    logic [CNT_WIDTH-1:0] zero_count_q, zero_count_d;
    logic                 accept;

    assign in_ready        = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept          = in_valid && in_ready;
    assign div_dividend    = div_dividend_q;
    assign div_divisor     = div_divisor_q;
    assign out_valid       = valid_q;
    assign out_quotient    = quotient_q;
    assign out_div_by_zero = dbz_q;
    assign zero_count      = zero_count_q;

    // State register and datapath registers; reset parks the divider on 0/1.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            wait_q         <= '0;
            div_dividend_q <= '0;
            div_divisor_q  <= SIZE_DATA'(1);
            quotient_q     <= '0;
            valid_q        <= 1'b0;
            dbz_q          <= 1'b0;
            zero_count_q   <= '0;
        end else begin
            state_q        <= state_d;
            wait_q         <= wait_d;
            div_dividend_q <= div_dividend_d;
            div_divisor_q  <= div_divisor_d;
            quotient_q     <= quotient_d;
            valid_q        <= valid_d;
            dbz_q          <= dbz_d;
            zero_count_q   <= zero_count_d;
        end
    end

    // Next-state and datapath updates for the IDLE/WAIT/DONE sequence.
    always_comb begin
        state_d        = state_q;
        wait_d         = wait_q;
        div_dividend_d = div_dividend_q;
        div_divisor_d  = div_divisor_q;
        quotient_d     = quotient_q;
        valid_d        = valid_q;
        dbz_d          = dbz_q;
        zero_count_d   = zero_count_q;

        case (state_q)
            WAIT: begin
                if (wait_q == '0) begin
                    quotient_d = div_quotient;
                    dbz_d      = 1'b0;
                    valid_d    = 1'b1;
                    state_d    = DONE;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: ;
        endcase

        // Accept can only happen in IDLE or on the DONE hand-off edge, so it
        // overrides the release above and starts the new transaction directly.
        if (accept) begin
            if (in_divisor != '0) begin
                div_dividend_d = in_dividend;
                div_divisor_d  = in_divisor;
                wait_d         = WAIT_W'(DIV_LATENCY);
                valid_d        = 1'b0;
                state_d        = WAIT;
            end else begin
                quotient_d = '1;
                dbz_d      = 1'b1;
                valid_d    = 1'b1;
                state_d    = DONE;
                if (zero_count_q != '1) begin
                    zero_count_d = zero_count_q + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_divider_sequencer.sv
// Directed bench for divider_sequencer with a one-cycle divider model.
module tb_divider_sequencer;
    import package_settings::*;

    logic                 clk;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic [SIZE_DATA-1:0] in_dividend;
    logic [SIZE_DATA-1:0] in_divisor;
    logic [SIZE_DATA-1:0] div_dividend;
    logic [SIZE_DATA-1:0] div_divisor;
    logic [SIZE_DATA-1:0] div_quotient;
    logic                 out_valid;
    logic                 out_ready;
    logic [SIZE_DATA-1:0] out_quotient;
    logic                 out_div_by_zero;
    logic [15:0]          zero_count;

    logic                 in_valid2;
    logic                 in_ready2;
    logic [SIZE_DATA-1:0] in_dividend2;
    logic [SIZE_DATA-1:0] in_divisor2;
    logic [SIZE_DATA-1:0] div_dividend2;
    logic [SIZE_DATA-1:0] div_divisor2;
    logic [SIZE_DATA-1:0] div_quotient2;
    logic                 out_valid2;
    logic                 out_ready2;
    logic [SIZE_DATA-1:0] out_quotient2;
    logic                 out_div_by_zero2;
    logic [1:0]           zero_count2;

    int unsigned n_checks;
    int unsigned n_fail;

    divider_sequencer #(.DIV_LATENCY(1), .CNT_WIDTH(16)) u_dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_dividend     (in_dividend),
        .in_divisor      (in_divisor),
        .div_dividend    (div_dividend),
        .div_divisor     (div_divisor),
        .div_quotient    (div_quotient),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_quotient    (out_quotient),
        .out_div_by_zero (out_div_by_zero),
        .zero_count      (zero_count)
    );

    divider_sequencer #(.DIV_LATENCY(1), .CNT_WIDTH(2)) u_dut_sat (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid2),
        .in_ready        (in_ready2),
        .in_dividend     (in_dividend2),
        .in_divisor      (in_divisor2),
        .div_dividend    (div_dividend2),
        .div_divisor     (div_divisor2),
        .div_quotient    (div_quotient2),
        .out_valid       (out_valid2),
        .out_ready       (out_ready2),
        .out_quotient    (out_quotient2),
        .out_div_by_zero (out_div_by_zero2),
        .zero_count      (zero_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural divider with one cycle of latency.
    always @(posedge clk) begin
        if (div_divisor != '0) div_quotient <= div_dividend / div_divisor;
        else                   div_quotient <= '1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [SIZE_DATA-1:0] a, input logic [SIZE_DATA-1:0] b);
        in_valid    = v;
        in_dividend = a;
        in_divisor  = b;
    endtask

    logic [1:0] sat_exp [5];

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        div_quotient  = '0;
        div_quotient2 = '0;
        reset         = 1'b1;
        out_ready     = 1'b1;
        drive(1'b0, '0, '0);
        in_valid2     = 1'b0;
        in_dividend2  = '0;
        in_divisor2   = '0;
        out_ready2    = 1'b1;
        sat_exp       = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        step();
        step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_quotient", 32'(out_quotient), 32'd0);
        check("rst_dbz", 32'(out_div_by_zero), 32'd0);
        check("rst_div_dividend", 32'(div_dividend), 32'd0);
        check("rst_div_divisor", 32'(div_divisor), 32'd1);
        check("rst_zero_count", 32'(zero_count), 32'd0);
        reset = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // 100 / 7 -> 14, valid two cycles after accept
        drive(1'b1, 16'd100, 16'd7);
        step();
        drive(1'b0, '0, '0);
        check("t1_valid_e0", 32'(out_valid), 32'd0);
        check("t1_div_dividend", 32'(div_dividend), 32'd100);
        check("t1_div_divisor", 32'(div_divisor), 32'd7);
        check("t1_in_ready_wait", 32'(in_ready), 32'd0);
        step();
        check("t1_valid_e1", 32'(out_valid), 32'd0);
        step();
        check("t1_valid_e2", 32'(out_valid), 32'd1);
        check("t1_quotient", 32'(out_quotient), 32'd14);
        check("t1_dbz", 32'(out_div_by_zero), 32'd0);
        step();
        check("t1_released", 32'(out_valid), 32'd0);

        // 50 / 0 -> all ones with flag, divisor register untouched
        drive(1'b1, 16'd50, 16'd0);
        step();
        drive(1'b0, '0, '0);
        check("t3_valid", 32'(out_valid), 32'd1);
        check("t3_quotient", 32'(out_quotient), 32'hFFFF);
        check("t3_dbz", 32'(out_div_by_zero), 32'd1);
        check("t3_zero_count", 32'(zero_count), 32'd1);
        check("t3_div_divisor", 32'(div_divisor), 32'd7);
        check("t3_div_dividend", 32'(div_dividend), 32'd100);
        step();
        check("t3_released", 32'(out_valid), 32'd0);

        // 0xFFFF / 1 with downstream stalled
        out_ready = 1'b0;
        drive(1'b1, 16'hFFFF, 16'd1);
        step();
        drive(1'b0, '0, '0);
        check("t2_in_ready_wait", 32'(in_ready), 32'd0);
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_valid", 32'(out_valid), 32'd1);
            check("t2_hold_quotient", 32'(out_quotient), 32'hFFFF);
            check("t2_hold_in_ready", 32'(in_ready), 32'd0);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("t2_in_ready_release", 32'(in_ready), 32'd1);
        step();
        check("t2_released", 32'(out_valid), 32'd0);

        // back-to-back 9/3 then 8/0 accepted on the DONE edge
        drive(1'b1, 16'd9, 16'd3);
        step();
        drive(1'b1, 16'd8, 16'd0);
        step();
        check("t4_valid_e1", 32'(out_valid), 32'd0);
        step();
        check("t4_valid_first", 32'(out_valid), 32'd1);
        check("t4_quotient_first", 32'(out_quotient), 32'd3);
        check("t4_dbz_first", 32'(out_div_by_zero), 32'd0);
        check("t4_in_ready_done", 32'(in_ready), 32'd1);
        step();
        drive(1'b0, '0, '0);
        check("t4_valid_second", 32'(out_valid), 32'd1);
        check("t4_quotient_second", 32'(out_quotient), 32'hFFFF);
        check("t4_dbz_second", 32'(out_div_by_zero), 32'd1);
        check("t4_zero_count", 32'(zero_count), 32'd2);
        check("t4_div_divisor", 32'(div_divisor), 32'd3);
        step();
        check("t4_released", 32'(out_valid), 32'd0);

        // reset during WAIT of 200/10 abandons the transaction
        drive(1'b1, 16'd200, 16'd10);
        step();
        drive(1'b0, '0, '0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t5_valid", 32'(out_valid), 32'd0);
        check("t5_quotient", 32'(out_quotient), 32'd0);
        check("t5_dbz", 32'(out_div_by_zero), 32'd0);
        check("t5_div_dividend", 32'(div_dividend), 32'd0);
        check("t5_div_divisor", 32'(div_divisor), 32'd1);
        check("t5_zero_count", 32'(zero_count), 32'd0);
        step();
        check("t5_no_result_a", 32'(out_valid), 32'd0);
        step();
        check("t5_no_result_b", 32'(out_valid), 32'd0);
        drive(1'b1, 16'd20, 16'd4);
        step();
        drive(1'b0, '0, '0);
        step();
        step();
        check("t5_after_valid", 32'(out_valid), 32'd1);
        check("t5_after_quotient", 32'(out_quotient), 32'd5);
        step();

        // 2-bit zero counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            in_valid2    = 1'b1;
            in_dividend2 = 16'(i + 1);
            in_divisor2  = '0;
            step();
            in_valid2 = 1'b0;
            check("t6_valid", 32'(out_valid2), 32'd1);
            check("t6_zero_count", 32'(zero_count2), 32'(sat_exp[i]));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
